// File: rtl/counter4_if.sv
// counter4 bus: count enable in, count and overflow flag out.
// The master drives inc; the slave (the counter) drives cnt and wrap.
interface counter4_if #(
   parameter int WIDTH = 4
) ();
   logic             inc;
   logic [WIDTH-1:0] cnt;
   logic             wrap;

   modport master (
      output inc,
      input  cnt,
      input  wrap
   );

   modport slave (
      input  inc,
      output cnt,
      output wrap
   );
endinterface

// File: rtl/counter4.sv
// counter4: enable-gated up counter with a registered one-cycle wrap flag.
// Optional macro COUNTER4_SAT_EN makes the counter saturate at its maximum.
module counter4 #(
   parameter int WIDTH   = 4,
   parameter int RST_VAL = 0
) (
   input  logic      clk,
   input  logic      rstn,
   counter4_if.slave bus
);
   localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] LP_MAX = {WIDTH{1'b1}};
`ifdef COUNTER4_SAT_EN
   localparam logic [WIDTH-1:0] LP_PRE = LP_MAX - WIDTH'(1);
`endif

   // Initialisers give defined outputs before the first reset edge.
   logic [WIDTH-1:0] r_cnt_q = LP_RST;
   logic             r_wrap  = 1'b0;

   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_wrap_nxt;
   logic             w_at_max;

   assign w_at_max = (r_cnt_q == LP_MAX);
   assign bus.cnt  = r_cnt_q;
   assign bus.wrap = r_wrap;

   // Next count and overflow flag taken on an enabled edge.
   always_comb begin
      w_cnt_nxt  = r_cnt_q + WIDTH'(1);
      w_wrap_nxt = w_at_max;
`ifdef COUNTER4_SAT_EN
      if (w_at_max) begin
         w_cnt_nxt  = r_cnt_q;
         w_wrap_nxt = 1'b0;
      end else begin
         w_wrap_nxt = (r_cnt_q == LP_PRE);
      end
`endif
   end

   // State update: reset beats enable, idle edges clear the flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt_q <= LP_RST;
         r_wrap  <= 1'b0;
      end else if (bus.inc) begin
         r_cnt_q <= w_cnt_nxt;
         r_wrap  <= w_wrap_nxt;
      end else begin
         r_wrap  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_counter4.sv
// tb_counter4: directed tests for counter4 (default width 4, reset value 0).
// Build with COUNTER4_SAT_EN defined to exercise the saturating variant.
module tb_counter4;
   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   counter4_if #(.WIDTH(4)) bus ();

   counter4 #(
      .WIDTH   (4),
      .RST_VAL (0)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected count after one enabled edge from e.
   function automatic logic [3:0] exp_next(input logic [3:0] e);
`ifdef COUNTER4_SAT_EN
      return (e == 4'd15) ? 4'd15 : e + 4'd1;
`else
      return e + 4'd1;
`endif
   endfunction

   // Expected wrap flag after one enabled edge from e.
   function automatic logic exp_wrap(input logic [3:0] e);
`ifdef COUNTER4_SAT_EN
      return (e == 4'd14);
`else
      return (e == 4'd15);
`endif
   endfunction

   // One rising edge; returns at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Synchronous reset, then n enabled edges (no checks here).
   task automatic go_to(input int n);
      rstn    = 1'b0;
      bus.inc = 1'b1;
      step();
      rstn = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      logic [3:0] e;
      logic       w;
      checks++;
      if (bus.cnt !== 4'd0 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL powerup_state cnt=%0d wrap=%b want cnt=0 wrap=0",
                  bus.cnt, bus.wrap);
      end
      e = 4'd0;
      for (int i = 0; i < 17; i++) begin
         w = exp_wrap(e);
         e = exp_next(e);
         step();
         checks++;
         if (bus.cnt !== e || bus.wrap !== w) begin
            errors++;
            $display("FAIL powerup_count[%0d] cnt=%0d wrap=%b want %0d %b",
                     i, bus.cnt, bus.wrap, e, w);
         end
      end
   endtask

   task automatic test_count20();
      logic [3:0] e;
      logic       w;
      rstn    = 1'b0;
      bus.inc = 1'b1;
      step();
      checks++;
      if (bus.cnt !== 4'd0 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL count20_reset cnt=%0d wrap=%b want 0 0",
                  bus.cnt, bus.wrap);
      end
      rstn = 1'b1;
      e = 4'd0;
      for (int i = 0; i < 20; i++) begin
         w = exp_wrap(e);
         e = exp_next(e);
         step();
         checks++;
         if (bus.cnt !== e || bus.wrap !== w) begin
            errors++;
            $display("FAIL count20[%0d] cnt=%0d wrap=%b want %0d %b",
                     i, bus.cnt, bus.wrap, e, w);
         end
      end
   endtask

   task automatic test_toggle();
      logic       pat [4];
      logic [3:0] want [4];
      pat  = '{1'b1, 1'b0, 1'b1, 1'b0};
      want = '{4'd6, 4'd6, 4'd7, 4'd7};
      go_to(5);
      checks++;
      if (bus.cnt !== 4'd5) begin
         errors++;
         $display("FAIL toggle_start cnt=%0d want 5", bus.cnt);
      end
      for (int i = 0; i < 4; i++) begin
         bus.inc = pat[i];
         step();
         checks++;
         if (bus.cnt !== want[i] || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL toggle[%0d] cnt=%0d wrap=%b want %0d 0",
                     i, bus.cnt, bus.wrap, want[i]);
         end
      end
   endtask

   task automatic test_reset_midcount();
      go_to(9);
      rstn    = 1'b0;
      bus.inc = 1'b1;
      step();
      checks++;
      if (bus.cnt !== 4'd0 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL midreset cnt=%0d wrap=%b want 0 0",
                  bus.cnt, bus.wrap);
      end
      rstn = 1'b1;
      step();
      checks++;
      if (bus.cnt !== 4'd1) begin
         errors++;
         $display("FAIL midreset_resume1 cnt=%0d want 1", bus.cnt);
      end
      step();
      checks++;
      if (bus.cnt !== 4'd2) begin
         errors++;
         $display("FAIL midreset_resume2 cnt=%0d want 2", bus.cnt);
      end
   endtask

   task automatic test_reset_wins();
      go_to(15);
      checks++;
      if (bus.cnt !== 4'd15) begin
         errors++;
         $display("FAIL rstwins_start cnt=%0d want 15", bus.cnt);
      end
      rstn    = 1'b0;
      bus.inc = 1'b1;
      step();
      rstn = 1'b1;
      checks++;
      if (bus.cnt !== 4'd0 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL rstwins cnt=%0d wrap=%b want 0 0",
                  bus.cnt, bus.wrap);
      end
   endtask

   task automatic test_hold_max();
      logic [3:0] e;
      logic       w;
      go_to(15);
      bus.inc = 1'b0;
      step();
      checks++;
      if (bus.cnt !== 4'd15 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL holdmax_idle cnt=%0d wrap=%b want 15 0",
                  bus.cnt, bus.wrap);
      end
      bus.inc = 1'b1;
      w = exp_wrap(4'd15);
      e = exp_next(4'd15);
      step();
      checks++;
      if (bus.cnt !== e || bus.wrap !== w) begin
         errors++;
         $display("FAIL holdmax_inc cnt=%0d wrap=%b want %0d %b",
                  bus.cnt, bus.wrap, e, w);
      end
      bus.inc = 1'b0;
      step();
      checks++;
      if (bus.cnt !== e || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL holdmax_pulse cnt=%0d wrap=%b want %0d 0",
                  bus.cnt, bus.wrap, e);
      end
   endtask

`ifdef COUNTER4_SAT_EN
   task automatic test_sat();
      int pulses;
      pulses = 0;
      go_to(0);
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.wrap === 1'b1) pulses++;
      end
      checks++;
      if (bus.cnt !== 4'd15 || pulses !== 1) begin
         errors++;
         $display("FAIL sat20 cnt=%0d pulses=%0d want 15 1",
                  bus.cnt, pulses);
      end
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      rstn    = 1'b0;
      bus.inc = 1'b1;
      #1;
      rstn = 1'b1;
      test_reset();
      test_count20();
      test_toggle();
      test_reset_midcount();
      test_reset_wins();
      test_hold_max();
`ifdef COUNTER4_SAT_EN
      test_sat();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
